// File: rtl/beta_pkg.sv
// Shared types and constants for the Beta register file.
package beta_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] R31 = 5'd31;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_READY = 1'b1
   } rf_state_t;

endpackage

// File: rtl/beta_rf_wdec.sv
// One-hot write-enable decoder; the top entry (hard-wired zero register) never enables.
module beta_rf_wdec #(
   parameter int unsigned N  = 32,
   parameter int unsigned AW = 5
) (
   input  logic [AW-1:0] addr,
   input  logic          en,
   output logic [N-1:0]  we
);

   always_comb begin
      we = '0;
      if (en) we[addr] = 1'b1;
      we[N-1] = 1'b0;
   end

endmodule

// File: rtl/beta_regfile.sv
// Beta 32x32 register file: two combinational read ports, one write port, post-reset clear.
// Optional write-through read bypass when REGFILE_BYPASS_EN is defined.
module beta_regfile
   import beta_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_W,
   parameter int unsigned NREGS = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [$clog2(NREGS)-1:0] ra1,
   output logic [WIDTH-1:0]         rd1,
   input  logic [$clog2(NREGS)-1:0] ra2,
   output logic [WIDTH-1:0]         rd2,
   input  logic [$clog2(NREGS)-1:0] wa,
   input  logic [WIDTH-1:0]         wd,
   input  logic                     werf,
   output logic                     busy
);

   localparam int unsigned AW = $clog2(NREGS);
   localparam logic [AW-1:0] ZERO_REG = AW'(NREGS - 1);
   localparam logic [AW-1:0] LAST_CLR = AW'(NREGS - 2);

   rf_state_t        state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [NREGS];

   logic [AW-1:0]    dec_addr;
   logic             dec_en;
   logic [NREGS-1:0] we;
   logic [WIDTH-1:0] wdata;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RF_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: clear walks R0..R(NREGS-2), then parks in READY
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RF_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CLR) state_d = RF_READY;
         end
         RF_READY: ;
         default: begin
            state_d = RF_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: the sequencer owns the write port while clearing
   always_comb begin
      busy     = 1'b1;
      dec_addr = wa;
      dec_en   = 1'b0;
      wdata    = wd;
      case (state_q)
         RF_CLEAR: begin
            dec_addr = cnt_q;
            dec_en   = ~reset;
            wdata    = '0;
         end
         RF_READY: begin
            busy   = 1'b0;
            dec_en = werf & ~reset;
         end
         default: ;
      endcase
   end

   beta_rf_wdec #(.N(NREGS), .AW(AW)) u_wdec (
      .addr (dec_addr),
      .en   (dec_en),
      .we   (we)
   );

   always_ff @(posedge clk) begin
      for (int i = 0; i < NREGS; i++) begin
         if (we[i]) mem_q[i] <= wdata;
      end
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (!busy && ra1 != ZERO_REG) rd1 = mem_q[ra1];
      if (!busy && ra2 != ZERO_REG) rd2 = mem_q[ra2];
`ifdef REGFILE_BYPASS_EN
      if (!busy && werf && wa != ZERO_REG && ra1 == wa) rd1 = wd;
      if (!busy && werf && wa != ZERO_REG && ra2 == wa) rd2 = wd;
`endif
   end

endmodule
